regfile_scoreboard: RTL and testbench

//   Parametrised multi-port register file with a per-register busy scoreboard, for the pipelined CPU.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_scoreboard_if.sv | 28 ++
 rtl/regfile_entry.sv | 22 ++
 rtl/regfile_scoreboard.sv | 65 ++++++
 tb/tb_regfile_scoreboard.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: width helpers shared by the register file, its interface and entries
package regfile_pkg;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, write and reserve signals of the register file scoreboard
interface regfile_scoreboard_if import regfile_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  logic [READ_PORTS*ADDR_W-1:0] ReadRegister;
  logic [READ_PORTS*WIDTH-1:0]  ReadData;
  logic [READ_PORTS-1:0]        ReadBusy;
  logic                         RegWrite;
  logic [ADDR_W-1:0]            WriteRegister;
  logic [WIDTH-1:0]             WriteData;
  logic [WIDTH/8-1:0]           WriteByteEn;
  logic                         Reserve;
  logic [ADDR_W-1:0]            ReserveRegister;
  logic                         ReserveReady;
  logic [CNT_W-1:0]             PendingCount;
  modport master (
    output ReadRegister, RegWrite, WriteRegister, WriteData, WriteByteEn, Reserve, ReserveRegister,
    input  ReadData, ReadBusy, ReserveReady, PendingCount
  );
  modport slave (
    input  ReadRegister, RegWrite, WriteRegister, WriteData, WriteByteEn, Reserve, ReserveRegister,
    output ReadData, ReadBusy, ReserveReady, PendingCount
  );
endinterface

// File: rtl/regfile_entry.sv
// regfile_entry: one register with per-byte write enables and async clear
module regfile_entry #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [WIDTH-1:0]   d_i,
  output logic [WIDTH-1:0]   q_o
);
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    data_d = data_q;
    for (int b = 0; b < WIDTH/8; b++)
      if (we_i && be_i[b]) data_d[b*8 +: 8] = d_i[b*8 +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  assign q_o = data_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with write bypass and busy scoreboard
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                 Clk,
  input logic                 Reset_n,
  regfile_scoreboard_if.slave rf
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  logic [WIDTH-1:0] ent [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic wr_en, acc, rel;
  assign wr_en           = rf.RegWrite && !(ZERO_REG != 0 && rf.WriteRegister == '0);
  assign rf.ReserveReady = !busy_q[rf.ReserveRegister] && !(ZERO_REG != 0 && rf.ReserveRegister == '0);
  assign acc             = rf.Reserve && rf.ReserveReady;
  assign rel             = wr_en && busy_q[rf.WriteRegister];
  // A reserve of an idle register being written in the same cycle wins: the new producer owns it
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[rf.WriteRegister] = 1'b0;
    if (acc)   busy_d[rf.ReserveRegister] = 1'b1;
    pend_d = pend_q + CNT_W'(acc) - CNT_W'(rel);
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  assign rf.PendingCount = pend_q;
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    if (ZERO_REG != 0 && g == 0) begin : g_zero
      assign ent[g] = '0;
    end else begin : g_reg
      regfile_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we_i  (wr_en && rf.WriteRegister == ADDR_W'(g)),
        .be_i  (rf.WriteByteEn),
        .d_i   (rf.WriteData),
        .q_o   (ent[g])
      );
    end
  end
  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;
    logic [WIDTH-1:0]  fwd;
    assign ra  = rf.ReadRegister[k*ADDR_W +: ADDR_W];
    assign byp = BYPASS != 0 && wr_en && rf.WriteRegister == ra;
    for (genvar b = 0; b < WIDTH/8; b++) begin : g_byte
      assign fwd[b*8 +: 8] = rf.WriteByteEn[b] ? rf.WriteData[b*8 +: 8] : ent[ra][b*8 +: 8];
    end
    assign rf.ReadData[k*WIDTH +: WIDTH] = byp ? fwd : ent[ra];
    assign rf.ReadBusy[k]                = busy_q[ra] && !byp;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed table, corner sequences and random run against a reference model
module tb_regfile_scoreboard;
  localparam int W = 32, D = 32, RP = 2;
  logic Clk = 1'b0, Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  regfile_scoreboard_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP)) ifa ();
  regfile_scoreboard_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP)) ifb ();
  assign ifb.ReadRegister    = ifa.ReadRegister;
  assign ifb.RegWrite        = ifa.RegWrite;
  assign ifb.WriteRegister   = ifa.WriteRegister;
  assign ifb.WriteData       = ifa.WriteData;
  assign ifb.WriteByteEn     = ifa.WriteByteEn;
  assign ifb.Reserve         = ifa.Reserve;
  assign ifb.ReserveRegister = ifa.ReserveRegister;
  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .ZERO_REG(1), .BYPASS(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .rf(ifa.slave));
  regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .rf(ifb.slave));

  int pass_cnt = 0, total_cnt = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic res, input logic [4:0] rr, input logic [4:0] ra0, input logic [4:0] ra1);
    ifa.RegWrite = we; ifa.WriteRegister = wa; ifa.WriteData = wd; ifa.WriteByteEn = be;
    ifa.Reserve = res; ifa.ReserveRegister = rr; ifa.ReadRegister = {ra1, ra0};
  endtask

  function automatic logic [31:0] rd(input int k);
    return ifa.ReadData[k*W +: W];
  endfunction
  function automatic logic [31:0] rd_nb(input int k);
    return ifb.ReadData[k*W +: W];
  endfunction

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [3:0] be;
    logic res; logic [4:0] rr; logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] e0; logic [31:0] e1; logic [31:0] enb1;
    logic [1:0] ebusy; logic erdy; logic [5:0] epend;
  } vec_t;
  function automatic vec_t v(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                             input logic res, input logic [4:0] rr, input logic [4:0] ra0, input logic [4:0] ra1,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] enb1,
                             input logic [1:0] ebusy, input logic erdy, input logic [5:0] epend);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd; t.be = be; t.res = res; t.rr = rr; t.ra0 = ra0; t.ra1 = ra1;
    t.e0 = e0; t.e1 = e1; t.enb1 = enb1; t.ebusy = ebusy; t.erdy = erdy; t.epend = epend;
    return t;
  endfunction

  // Reference model: plain arrays, pending count is simply the number of busy registers
  logic [31:0] mem [D];
  bit          mbusy [D];
  function automatic logic [31:0] mread(input int a, input bit byp);
    logic [31:0] r;
    if (a == 0) return 32'h0;
    r = mem[a];
    if (byp && ifa.RegWrite && int'(ifa.WriteRegister) == a)
      for (int b = 0; b < 4; b++) if (ifa.WriteByteEn[b]) r[b*8 +: 8] = ifa.WriteData[b*8 +: 8];
    return r;
  endfunction
  function automatic bit mbusy_rd(input int a, input bit byp);
    return a != 0 && mbusy[a] && !(byp && ifa.RegWrite && int'(ifa.WriteRegister) == a);
  endfunction
  function automatic int mpend();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(mbusy[i]);
    return n;
  endfunction
  function automatic bit mready();
    return ifa.ReserveRegister != 0 && !mbusy[ifa.ReserveRegister];
  endfunction
  task automatic mstep();
    bit rdy = mready();
    int wa = int'(ifa.WriteRegister);
    if (ifa.RegWrite && wa != 0) begin
      for (int b = 0; b < 4; b++) if (ifa.WriteByteEn[b]) mem[wa][b*8 +: 8] = ifa.WriteData[b*8 +: 8];
      mbusy[wa] = 0;
    end
    if (ifa.Reserve && rdy) mbusy[ifa.ReserveRegister] = 1;
  endtask
  task automatic mclear();
    for (int i = 0; i < D; i++) begin mem[i] = '0; mbusy[i] = 0; end
  endtask

  vec_t tbl [12];
  initial begin
    tbl[0]  = v(1, 5, 32'hDEADBEEF, 4'h5, 0, 0, 5, 5, 32'h00AD00EF, 32'h00AD00EF, 32'h0, 2'b00, 0, 0);
    tbl[1]  = v(0, 0, 32'h0, 4'h0, 0, 3, 5, 0, 32'h00AD00EF, 32'h0, 32'h0, 2'b00, 1, 0);
    tbl[2]  = v(1, 0, 32'hFFFFFFFF, 4'hF, 0, 3, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00, 1, 0);
    tbl[3]  = v(1, 7, 32'h12345678, 4'hF, 0, 3, 0, 7, 32'h0, 32'h12345678, 32'h0, 2'b00, 1, 0);
    tbl[4]  = v(0, 0, 32'h0, 4'h0, 1, 3, 3, 7, 32'h0, 32'h12345678, 32'h12345678, 2'b00, 1, 0);
    tbl[5]  = v(0, 0, 32'h0, 4'h0, 1, 3, 3, 7, 32'h0, 32'h12345678, 32'h12345678, 2'b01, 0, 1);
    tbl[6]  = v(1, 3, 32'h0000AAAA, 4'hF, 0, 3, 3, 3, 32'h0000AAAA, 32'h0000AAAA, 32'h0, 2'b00, 0, 1);
    tbl[7]  = v(0, 0, 32'h0, 4'h0, 1, 9, 3, 3, 32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA, 2'b00, 1, 0);
    tbl[8]  = v(1, 9, 32'h1, 4'hF, 1, 9, 9, 4, 32'h1, 32'h0, 32'h0, 2'b00, 0, 1);
    tbl[9]  = v(0, 0, 32'h0, 4'h0, 1, 9, 9, 4, 32'h1, 32'h0, 32'h0, 2'b00, 1, 0);
    tbl[10] = v(1, 9, 32'hFFFFFFFF, 4'h0, 1, 4, 9, 4, 32'h1, 32'h0, 32'h0, 2'b00, 1, 1);
    tbl[11] = v(0, 0, 32'h0, 4'h0, 0, 4, 9, 4, 32'h1, 32'h0, 32'h0, 2'b10, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    for (int a = 0; a < D; a++) begin
      drive(0, 0, 0, 0, 0, 5'(a), 5'(a), 5'(31 - a));
      #1;
      chk("rst_rd0", rd(0), 0);
      chk("rst_rd1", rd(1), 0);
      chk("rst_busy", ifa.ReadBusy, 0);
      chk("rst_pend", ifa.PendingCount, 0);
      chk("rst_ready", ifa.ReserveReady, a != 0);
    end
    @(negedge Clk) Reset_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].res, tbl[i].rr, tbl[i].ra0, tbl[i].ra1);
      #4;
      chk($sformatf("tbl%0d_rd0", i), rd(0), tbl[i].e0);
      chk($sformatf("tbl%0d_rd1", i), rd(1), tbl[i].e1);
      chk($sformatf("tbl%0d_nb_rd1", i), rd_nb(1), tbl[i].enb1);
      chk($sformatf("tbl%0d_busy", i), ifa.ReadBusy, tbl[i].ebusy);
      chk($sformatf("tbl%0d_ready", i), ifa.ReserveReady, tbl[i].erdy);
      chk($sformatf("tbl%0d_pend", i), ifa.PendingCount, tbl[i].epend);
      @(posedge Clk); #1;
    end

    // r4 is still reserved from the table; add r1, r2, r3 then reset mid-cycle
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, 0, 0, 1, 5'(r), 0, 0);
      @(posedge Clk); #1;
    end
    drive(0, 0, 0, 0, 0, 1, 5, 3);
    #2;
    chk("pre_rst_pend", ifa.PendingCount, 4);
    chk("pre_rst_rd0", rd(0), 32'h00AD00EF);
    chk("pre_rst_busy", ifa.ReadBusy, 2'b10);
    chk("pre_rst_ready", ifa.ReserveReady, 0);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_rd0", rd(0), 0);
    chk("mid_rst_rd1", rd(1), 0);
    chk("mid_rst_busy", ifa.ReadBusy, 0);
    chk("mid_rst_pend", ifa.PendingCount, 0);
    chk("mid_rst_ready", ifa.ReserveReady, 1);
    #1 Reset_n = 1'b1;
    mclear();
    @(posedge Clk); #1;

    for (int i = 0; i < 1500; i++) begin
      int ra0 = (i % 3 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      int ra1 = int'($urandom_range(0, 7));
      drive(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 4'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), 5'(ra0), 5'(ra1));
      #4;
      chk("rnd_rd0", rd(0), mread(ra0, 1));
      chk("rnd_rd1", rd(1), mread(ra1, 1));
      chk("rnd_busy", ifa.ReadBusy, {mbusy_rd(ra1, 1), mbusy_rd(ra0, 1)});
      chk("rnd_nb_rd1", rd_nb(1), mread(ra1, 0));
      chk("rnd_nb_busy", ifb.ReadBusy, {mbusy_rd(ra1, 0), mbusy_rd(ra0, 0)});
      chk("rnd_ready", ifa.ReserveReady, mready());
      chk("rnd_pend", ifa.PendingCount, mpend());
      @(posedge Clk);
      mstep();
      #1;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
